// File: rtl/multi_cycle_pkg.sv
// Shared definitions for the multi-cycle sequencers: FSM state encoding,
// register-index width and small mask helpers.
package multi_cycle_pkg;

    localparam int unsigned REG_IDX_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_RFWRITE = 3'd2,
        ST_BASEWB  = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    function automatic logic [7:0] clear_bit(input logic [7:0] mask,
                                             input logic [REG_IDX_W-1:0] idx);
        clear_bit = mask & ~(8'b1 << idx);
    endfunction

endpackage

// File: rtl/lowest_set8.sv
// Priority encoder: index of the lowest set bit of an 8-bit mask, plus a
// flag that is high when any bit is set.
module lowest_set8
    import multi_cycle_pkg::*;
(
    input  logic [7:0]           mask,
    output logic [REG_IDX_W-1:0] idx,
    output logic                 valid
);

    logic found;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (mask[i] && !found) begin
                idx   = REG_IDX_W'(i);
                found = 1'b1;
            end
        end
        valid = found;
    end

endmodule

// File: rtl/block_transfer_seq.sv
// Load/store-multiple sequencer: walks a register list in ascending order,
// one memory access per selected register, with optional base writeback.
module block_transfer_seq
    import multi_cycle_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_load,
    input  logic [7:0]           reg_list,
    input  logic [W-1:0]         base_addr,
    input  logic                 writeback,
    input  logic [2:0]           base_reg,
    output logic [2:0]           rf_adr_src,
    input  logic [W-1:0]         rf_data_rd,
    output logic [2:0]           rf_adr_dst,
    output logic [W-1:0]         rf_data_wr,
    output logic                 rf_write_enable,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [W-1:0]         mem_addr,
    output logic [W-1:0]         mem_wdata,
    input  logic                 mem_ack,
    input  logic [W-1:0]         mem_rdata,
    output logic                 busy,
    output logic                 done
);

    state_e                 state_q, state_d;
    logic [7:0]             mask_q, mask_d;
    logic [W-1:0]           addr_q, addr_d;
    logic [W-1:0]           data_q, data_d;
    logic                   is_load_q, is_load_d;
    logic                   writeback_q, writeback_d;
    logic [2:0]             base_reg_q, base_reg_d;

    logic [REG_IDX_W-1:0]   cur_idx;
    logic                   cur_valid;
    logic [7:0]             mask_next;
    state_e                 after_access;

    lowest_set8 u_lowest (
        .mask  (mask_q),
        .idx   (cur_idx),
        .valid (cur_valid)
    );

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        addr_d      = addr_q;
        data_d      = data_q;
        is_load_d   = is_load_q;
        writeback_d = writeback_q;
        base_reg_d  = base_reg_q;

        mask_next    = clear_bit(mask_q, cur_idx);
        after_access = (mask_next != '0) ? ST_ACCESS :
                       (writeback_q ? ST_BASEWB : ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d      = reg_list;
                    addr_d      = base_addr;
                    is_load_d   = is_load;
                    writeback_d = writeback;
                    base_reg_d  = base_reg;
                    state_d     = (reg_list != '0) ? ST_ACCESS :
                                  (writeback ? ST_BASEWB : ST_DONE);
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    if (is_load_q) begin
                        data_d  = mem_rdata;
                        state_d = ST_RFWRITE;
                    end else begin
                        mask_d  = mask_next;
                        addr_d  = addr_q + W'(1);
                        state_d = after_access;
                    end
                end
            end
            ST_RFWRITE: begin
                mask_d  = mask_next;
                addr_d  = addr_q + W'(1);
                state_d = after_access;
            end
            ST_BASEWB: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            is_load_q   <= 1'b0;
            writeback_q <= 1'b0;
            base_reg_q  <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            is_load_q   <= is_load_d;
            writeback_q <= writeback_d;
            base_reg_q  <= base_reg_d;
        end
    end

    // Strobes are masked by reset so a transfer aborted mid-cycle never
    // commits a register write or issues a request in that cycle.
    always_comb begin
        mem_req         = (state_q == ST_ACCESS) && cur_valid && !reset;
        mem_we          = mem_req && !is_load_q;
        mem_addr        = (state_q == ST_ACCESS) ? addr_q : '0;
        mem_wdata       = (state_q == ST_ACCESS) ? rf_data_rd : '0;
        rf_adr_src      = (state_q == ST_ACCESS) ? cur_idx : '0;
        rf_write_enable = ((state_q == ST_RFWRITE) || (state_q == ST_BASEWB)) && !reset;
        rf_adr_dst      = '0;
        rf_data_wr      = '0;
        if (state_q == ST_RFWRITE) begin
            rf_adr_dst = cur_idx;
            rf_data_wr = data_q;
        end else if (state_q == ST_BASEWB) begin
            rf_adr_dst = base_reg_q;
            rf_data_wr = addr_q;
        end
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_block_transfer_seq.sv
// Scoreboard bench for block_transfer_seq: register-file and memory models,
// expected accesses/writes queued at start and checked as the DUT emits them.
module tb_block_transfer_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, start, is_load, writeback;
    logic [7:0]   reg_list;
    logic [W-1:0] base_addr;
    logic [2:0]   base_reg;
    logic [2:0]   rf_adr_src, rf_adr_dst;
    logic [W-1:0] rf_data_rd, rf_data_wr;
    logic         rf_write_enable;
    logic         mem_req, mem_we, mem_ack;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic         busy, done;

    typedef struct {
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] data;
    } mem_exp_t;

    typedef struct {
        logic [2:0]   idx;
        logic [W-1:0] data;
        logic         is_load;
    } rf_exp_t;

    mem_exp_t     exp_mem[$];
    rf_exp_t      exp_rf[$];
    logic [W-1:0] rf_model[8];
    logic [W-1:0] mem_model[256];

    int  compared   = 0;
    int  mismatched = 0;
    int  ack_delay  = 1;
    int  req_seen   = 0;
    int  ack_count  = 0;
    time last_ack_time = 0;

    always #5 clk = ~clk;

    assign rf_data_rd = rf_model[rf_adr_src];

    block_transfer_seq #(.W(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .is_load         (is_load),
        .reg_list        (reg_list),
        .base_addr       (base_addr),
        .writeback       (writeback),
        .base_reg        (base_reg),
        .rf_adr_src      (rf_adr_src),
        .rf_data_rd      (rf_data_rd),
        .rf_adr_dst      (rf_adr_dst),
        .rf_data_wr      (rf_data_wr),
        .rf_write_enable (rf_write_enable),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .busy            (busy),
        .done            (done)
    );

    task automatic mem_responder();
        int           cnt = 0;
        logic [W-1:0] h_addr = '0;
        logic [W-1:0] h_wdata = '0;
        mem_exp_t     e;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                cnt = 0;
            end
            if (mem_req) begin
                req_seen++;
                if (cnt == 0) begin
                    h_addr  = mem_addr;
                    h_wdata = mem_wdata;
                end else begin
                    compared++;
                    if (mem_addr !== h_addr || mem_wdata !== h_wdata) begin
                        mismatched++;
                        $display("FAIL req_hold: addr=%h wdata=%h, required addr=%h wdata=%h",
                                 mem_addr, mem_wdata, h_addr, h_wdata);
                    end
                end
                if (cnt == ack_delay) begin
                    compared++;
                    if (exp_mem.size() == 0) begin
                        mismatched++;
                        $display("FAIL unexpected_access: we=%b addr=%h, required none", mem_we, mem_addr);
                    end else begin
                        e = exp_mem.pop_front();
                        if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.data)) begin
                            mismatched++;
                            $display("FAIL mem_access: we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                                     mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
                        end
                    end
                    mem_rdata     = mem_model[mem_addr];
                    mem_ack       = 1'b1;
                    last_ack_time = $time;
                    ack_count++;
                end else begin
                    cnt++;
                end
            end
        end
    endtask

    task automatic rf_monitor();
        rf_exp_t e;
        forever begin
            @(negedge clk);
            if (rf_write_enable) begin
                compared++;
                if (exp_rf.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_rf_write: r%0d=%h, required none", rf_adr_dst, rf_data_wr);
                end else begin
                    e = exp_rf.pop_front();
                    if (rf_adr_dst !== e.idx || rf_data_wr !== e.data) begin
                        mismatched++;
                        $display("FAIL rf_write: r%0d=%h, required r%0d=%h", rf_adr_dst, rf_data_wr, e.idx, e.data);
                    end else if (e.is_load && $time != last_ack_time + 10) begin
                        mismatched++;
                        $display("FAIL rf_write_timing: at %0t, required %0t", $time, last_ack_time + 10);
                    end
                end
                rf_model[rf_adr_dst] = rf_data_wr;
            end
        end
    endtask

    task automatic run_xfer(input logic ld, input logic [7:0] list, input logic [W-1:0] base,
                            input logic wb, input logic [2:0] breg, input int budget,
                            output int cycles);
        logic [W-1:0] a;
        logic         got;
        @(posedge clk); #1;
        start = 1'b1; is_load = ld; reg_list = list; base_addr = base;
        writeback = wb; base_reg = breg;
        a = base;
        for (int unsigned i = 0; i < 8; i++) begin
            if (list[i]) begin
                exp_mem.push_back('{we: !ld, addr: a, data: rf_model[i]});
                if (ld) exp_rf.push_back('{idx: 3'(i), data: mem_model[a], is_load: 1'b1});
                a = a + 8'd1;
            end
        end
        if (wb) exp_rf.push_back('{idx: breg, data: a, is_load: 1'b0});
        got = 1'b0;
        cycles = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            cycles = n;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (n == 1) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        start = 1'b0;
        compared++;
        if (!got) begin
            mismatched++;
            $display("FAIL done_timeout: no done within %0d cycles, required done", budget);
        end
    endtask

    task automatic check_drained(input string name);
        compared++;
        if (exp_mem.size() != 0 || exp_rf.size() != 0) begin
            mismatched++;
            $display("FAIL %s_drained: pending mem=%0d rf=%0d, required 0/0", name, exp_mem.size(), exp_rf.size());
        end
        exp_mem.delete();
        exp_rf.delete();
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_idle: busy=%b done=%b, required 0 0", name, busy, done);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        logic [49:0] outs;
        outs = {mem_req, mem_we, mem_addr, mem_wdata, rf_write_enable, rf_adr_dst,
                rf_data_wr, rf_adr_src, busy, done};
        compared++;
        if (outs !== '0) begin
            mismatched++;
            $display("FAIL %s: outputs=%h, required 0", name, outs);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset_outputs");
    endtask

    task automatic test_store();
        int c, acks;
        rf_model[1] = 8'h11;
        rf_model[3] = 8'h33;
        ack_delay = 1;
        acks = ack_count;
        run_xfer(1'b0, 8'h0A, 8'h40, 1'b0, 3'd0, 40, c);
        compared++;
        if (ack_count - acks != 2) begin
            mismatched++;
            $display("FAIL store_access_count: %0d, required 2", ack_count - acks);
        end
        check_drained("store");
    endtask

    task automatic test_load();
        int c;
        mem_model[8'hF0] = 8'hAA;
        mem_model[8'hF1] = 8'hBB;
        ack_delay = 1;
        run_xfer(1'b1, 8'h81, 8'hF0, 1'b0, 3'd0, 40, c);
        check_drained("load");
        compared++;
        if (rf_model[0] !== 8'hAA || rf_model[7] !== 8'hBB) begin
            mismatched++;
            $display("FAIL load_regs: r0=%h r7=%h, required r0=aa r7=bb", rf_model[0], rf_model[7]);
        end
    endtask

    task automatic test_wb_overlap();
        int c;
        mem_model[8'hFF] = 8'h5C;
        rf_model[2] = 8'h99;
        ack_delay = 1;
        run_xfer(1'b1, 8'h04, 8'hFF, 1'b1, 3'd2, 40, c);
        check_drained("wb_overlap");
        compared++;
        if (rf_model[2] !== 8'h00) begin
            mismatched++;
            $display("FAIL wb_final: r2=%h, required 00", rf_model[2]);
        end
    endtask

    task automatic test_empty();
        int c, reqs;
        reqs = req_seen;
        run_xfer(1'b0, 8'h00, 8'h12, 1'b0, 3'd0, 20, c);
        compared++;
        if (c != 2) begin
            mismatched++;
            $display("FAIL empty_latency: done after %0d cycles, required 2", c);
        end
        compared++;
        if (req_seen != reqs) begin
            mismatched++;
            $display("FAIL empty_no_req: %0d request cycles, required 0", req_seen - reqs);
        end
        check_drained("empty");
    endtask

    task automatic test_stall();
        int c, acks;
        rf_model[1] = 8'hC1;
        rf_model[2] = 8'hC2;
        ack_delay = 5;
        acks = ack_count;
        fork
            run_xfer(1'b0, 8'h06, 8'h80, 1'b0, 3'd0, 60, c);
            begin
                repeat (4) @(posedge clk);
                #1;
                start = 1'b1; is_load = 1'b1; reg_list = 8'hFF; writeback = 1'b1; base_reg = 3'd5;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        compared++;
        if (ack_count - acks != 2) begin
            mismatched++;
            $display("FAIL stall_access_count: %0d, required 2", ack_count - acks);
        end
        check_drained("stall");
        ack_delay = 1;
    endtask

    task automatic test_reset_mid();
        int  c;
        logic got;
        rf_model[0] = 8'h77;
        mem_model[8'h20] = 8'h99;
        ack_delay = 1;
        @(posedge clk); #1;
        start = 1'b1; is_load = 1'b1; reg_list = 8'h01; base_addr = 8'h20;
        writeback = 1'b0; base_reg = 3'd0;
        exp_mem.push_back('{we: 1'b0, addr: 8'h20, data: 8'h00});
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk); #1;
            if (mem_ack) begin
                got = 1'b1;
                break;
            end
        end
        compared++;
        if (!got) begin
            mismatched++;
            $display("FAIL reset_mid_ack_timeout: no ack, required ack");
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if (rf_write_enable !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_we: rf_write_enable=%b, required 0", rf_write_enable);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset_mid_outputs");
        compared++;
        if (rf_model[0] !== 8'h77) begin
            mismatched++;
            $display("FAIL reset_mid_reg: r0=%h, required 77", rf_model[0]);
        end
        exp_mem.delete();
        exp_rf.delete();
        rf_model[4] = 8'h44;
        run_xfer(1'b0, 8'h10, 8'h60, 1'b1, 3'd6, 40, c);
        check_drained("after_reset");
        compared++;
        if (rf_model[6] !== 8'h61) begin
            mismatched++;
            $display("FAIL after_reset_wb: r6=%h, required 61", rf_model[6]);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; is_load = 1'b0; reg_list = '0; base_addr = '0;
        writeback = 1'b0; base_reg = '0; mem_ack = 1'b0; mem_rdata = '0;
        for (int unsigned i = 0; i < 8; i++) rf_model[i] = '0;
        for (int unsigned i = 0; i < 256; i++) mem_model[i] = 8'(i ^ 8'h5A);
        fork
            mem_responder();
            rf_monitor();
        join_none
        test_reset();
        test_store();
        test_load();
        test_wb_overlap();
        test_empty();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
